apb_master: RTL and testbench

APB initiator converting a single-outstanding command/response handshake into APB SETUP/ACCESS transfers. Sits between the SoC control logic (boot sequencer, interrupt service engine, debug port) and the APB peripheral bus. It drives transfers into peripherals such as the interrupt controller. It honours PREADY wait states, reports PSLVERR, and aborts hung transfers with a programmable timeout.

---
 rtl/apb_pkg.sv | 33 +++
 rtl/apb_master.sv | 158 +++++++++++++++
 tb/tb_apb_master.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB initiator and anything that talks to it:
//   - apb_state_e   : transfer FSM states (IDLE, SETUP, ACCESS, RESP)
//   - APB_ADDR_W    : default APB address width
//   - APB_DATA_W    : default APB data width
//   - apb_cmd_t     : one command as issued by the control logic
//   - apb_cnt_width : width of the wait-state counter for a given timeout
// -----------------------------------------------------------------------------
package apb_pkg;

   localparam int APB_ADDR_W = 5;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

   // The counter must hold 0..timeout; a disabled timeout still gets one bit.
   function automatic int apb_cnt_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// Converts a single-outstanding command/response handshake into APB
// SETUP/ACCESS transfers. Honours PREADY wait states, reports PSLVERR and
// aborts a transfer whose slave holds PREADY low for TIMEOUT ACCESS cycles.
//
// Parameters
//   ADDR_W   APB address width
//   DATA_W   APB data width
//   TIMEOUT  ACCESS cycles with PREADY low before abort (0 = never abort)
//
// Ports
//   pclk, rstn                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_write/addr/wdata       command payload (wdata ignored for reads)
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata                  read data (0 for writes and timeouts)
//   rsp_err                    PSLVERR seen at completion, or timeout
//   rsp_timeout                transfer aborted by the timeout
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB request side
//   PRDATA/PREADY/PSLVERR              APB completion side
// -----------------------------------------------------------------------------
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              rstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int               CNT_W    = apb_cnt_width(TIMEOUT);
   localparam bit               TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   apb_state_e        r_state;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_rsp_timeout;

   // Set on the ACCESS cycle that is the TIMEOUT-th consecutive PREADY-low one.
   logic w_timeout_hit;
   assign w_timeout_hit = TO_EN && (r_wait_cnt == CNT_LAST);

   // Accepting in IDLE only keeps exactly one transfer outstanding.
   assign cmd_ready   = (r_state == IDLE);
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWRITE      = r_pwrite;
   assign PADDR       = r_paddr;
   assign PWDATA      = r_pwdata;

   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         r_state       <= IDLE;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_wait_cnt    <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // Request fields are loaded only here, so they hold their
               // value through the transfer and afterwards until the next one.
               if (cmd_valid) begin
                  r_pwrite <= cmd_write;
                  r_paddr  <= cmd_addr;
                  r_pwdata <= cmd_wdata;
                  r_psel   <= 1'b1;
                  r_state  <= SETUP;
               end
            end

            SETUP: begin
               // PREADY is deliberately not looked at in SETUP.
               r_penable  <= 1'b1;
               r_wait_cnt <= '0;
               r_state    <= ACCESS;
            end

            ACCESS: begin
               // Completion is tested first so that PREADY on the same cycle
               // the timeout would fire still yields a normal response.
               if (PREADY) begin
                  r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
                  r_rsp_err     <= PSLVERR;
                  r_rsp_timeout <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_state       <= RESP;
               end else if (w_timeout_hit) begin
                  r_rsp_rdata   <= '0;
                  r_rsp_err     <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  r_rsp_valid   <= 1'b1;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_state       <= RESP;
               end else if (TO_EN) begin
                  // Cannot wrap: the abort above fires before the top value.
                  r_wait_cnt <= r_wait_cnt + CNT_ONE;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Scoreboard bench for apb_master. A driver issues commands and, for each one,
// plans the slave's behaviour (wait states, PSLVERR, read data) and pushes the
// response the reference model predicts. A slave process plays the plan on the
// APB side; a monitor pops and compares each response the DUT presents.
// -----------------------------------------------------------------------------
module tb_apb_master;
   import apb_pkg::*;

   localparam int AW = APB_ADDR_W;
   localparam int DW = APB_DATA_W;
   localparam int TO = 16;

   logic          pclk = 1'b0;
   logic          rstn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA;
   logic          PREADY;
   logic          PSLVERR;

   apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .pclk        (pclk),
      .rstn        (rstn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      apb_cmd_t      cmd;
      int            waits;   // PREADY-low ACCESS cycles the slave inserts
      logic          err;
      logic [DW-1:0] rdata;
      int            acc;     // cycle (negedge count) of the accepting handshake
   } plan_t;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      logic          tmo;
      int            due;     // cycle in which rsp_valid must first be seen
   } exp_t;

   plan_t plan_q[$];
   exp_t  exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int rr_force = 1;          // -1: random rsp_ready, else forced to bit 0

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   // Reference model: the response the rules call for, from what the slave
   // is planned to do. Latency counts from the accepting edge: SETUP, then
   // waits+1 ACCESS cycles, or TO ACCESS cycles when the slave stalls too long.
   function automatic exp_t model(input plan_t p);
      exp_t e;
      if (TO != 0 && p.waits >= TO) begin
         e.rdata = '0;
         e.err   = 1'b1;
         e.tmo   = 1'b1;
         e.due   = p.acc + 2 + TO;
      end else begin
         e.rdata = p.cmd.write ? '0 : p.rdata;
         e.err   = p.err;
         e.tmo   = 1'b0;
         e.due   = p.acc + 3 + p.waits;
      end
      return e;
   endfunction

   // ---------------- driver ----------------
   task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int waits, input logic err, input logic [DW-1:0] rd,
                        input bit keep);
      plan_t p;
      int    k;
      @(posedge pclk); #1;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = wd;
      k = 0;
      forever begin
         @(negedge pclk);
         if (cmd_ready) break;
         k++;
         if (k > 300) begin
            chk("cmd_accept_timeout", 64'(k), 64'(0));
            cmd_valid = 1'b0;
            return;
         end
      end
      p.cmd.write = wr;
      p.cmd.addr  = a;
      p.cmd.wdata = wd;
      p.waits     = waits;
      p.err       = err;
      p.rdata     = (!wr && err) ? '0 : rd;
      p.acc       = cyc;
      plan_q.push_back(p);
      exp_q.push_back(model(p));
      @(posedge pclk); #1;
      if (!keep) begin
         cmd_valid = 1'b0;
         cmd_write = 1'($urandom);
         cmd_addr  = AW'($urandom);
         cmd_wdata = $urandom;
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (!(exp_q.size() == 0 && cmd_ready && !rsp_valid)) begin
         @(negedge pclk);
         k++;
         if (k > 400) begin
            chk("idle_wait_timeout", 64'(exp_q.size()), 64'(0));
            return;
         end
      end
   endtask

   initial begin
      rstn      = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rr_force  = 1;
      repeat (3) @(posedge pclk);
      #1;
      chk("rst_psel",    PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_pwrite",  PWRITE, 0);
      chk("rst_paddr",   PADDR, 0);
      chk("rst_pwdata",  PWDATA, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err",   rsp_err, 0);
      chk("rst_rsp_tmo",   rsp_timeout, 0);
      rstn = 1'b1;
      @(negedge pclk);
      chk("rst_cmd_ready", cmd_ready, 1);

      // Write, immediate PREADY
      issue(1'b1, 5'h04, 32'h0000_00F0, 0, 1'b0, '0, 1'b0);
      wait_idle();
      // Read with 3 wait states
      issue(1'b0, 5'h00, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
      wait_idle();
      // Read with PREADY stuck low: timeout
      issue(1'b0, 5'h1F, 32'h0, 1000, 1'b0, 32'h1234_5678, 1'b0);
      wait_idle();
      // Completion on the very cycle the timeout would fire
      issue(1'b0, 5'h03, 32'h0, TO - 1, 1'b0, 32'hCAFE_0001, 1'b0);
      wait_idle();
      // Exactly TO wait states: aborts
      issue(1'b1, 5'h05, 32'h7777_0000, TO, 1'b0, '0, 1'b0);
      wait_idle();
      // Write with PSLVERR
      issue(1'b1, 5'h08, 32'h0000_A5A5, 0, 1'b1, '0, 1'b0);
      wait_idle();

      // Back-pressure: response held 5 cycles while the next command waits
      rr_force = 0;
      issue(1'b1, 5'h0C, 32'h0000_0011, 0, 1'b0, '0, 1'b1);
      fork
         issue(1'b0, 5'h0C, 32'h0, 1, 1'b0, 32'h5555_AAAA, 1'b0);
         begin
            int k;
            k = 0;
            while (!rsp_valid && k < 50) begin
               @(negedge pclk);
               k++;
            end
            chk("bp_rsp_seen", rsp_valid, 1);
            repeat (5) @(posedge pclk);
            rr_force = 1;
         end
      join
      wait_idle();

      // Reset in the middle of ACCESS
      issue(1'b0, 5'h11, 32'h0, 1000, 1'b0, 32'h0BAD_0BAD, 1'b0);
      repeat (4) @(negedge pclk);
      chk("mid_psel_before", PSEL, 1);
      chk("mid_penable_before", PENABLE, 1);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_psel",    PSEL, 0);
      chk("mid_rst_penable", PENABLE, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      exp_q.delete();
      plan_q.delete();
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      rstn = 1'b1;
      @(negedge pclk);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      repeat (25) @(negedge pclk);

      // Random traffic
      rr_force = -1;
      for (int i = 0; i < 40; i++) begin
         int            sel;
         int            w;
         logic          wr;
         logic          er;
         sel = $urandom_range(0, 9);
         if (sel < 6)       w = $urandom_range(0, 3);
         else if (sel == 6) w = TO - 1;
         else if (sel == 7) w = TO;
         else if (sel == 8) w = TO + $urandom_range(1, 6);
         else               w = $urandom_range(4, TO - 2);
         wr = 1'($urandom);
         er = ($urandom_range(0, 4) == 0);
         issue(wr, AW'($urandom), $urandom, w, er, $urandom, 1'b0);
      end
      wait_idle();
      rr_force = 1;
      repeat (3) @(negedge pclk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- rsp_ready driver ----------------
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge pclk); #1;
         if (rr_force >= 0) rsp_ready = rr_force[0];
         else               rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- APB slave ----------------
   initial begin
      plan_t cur;
      bit    have;
      int    cnt;
      have    = 1'b0;
      cnt     = 0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
      forever begin
         @(negedge pclk);
         if (!rstn) begin
            have   = 1'b0;
            PREADY = 1'b0;
         end else if (PSEL && !PENABLE) begin
            if (plan_q.size() == 0) begin
               chk("setup_unexpected", 64'(PSEL), 64'(0));
               have = 1'b0;
            end else begin
               cur  = plan_q.pop_front();
               have = 1'b1;
               cnt  = cur.waits;
               chk("setup_cycle", 64'(cyc), 64'(cur.acc + 1));
               chk("setup_pwrite", PWRITE, cur.cmd.write);
               chk("setup_paddr",  PADDR,  cur.cmd.addr);
               chk("setup_pwdata", PWDATA, cur.cmd.wdata);
            end
            PREADY  = 1'($urandom);
            PSLVERR = 1'($urandom);
            PRDATA  = $urandom;
         end else if (PSEL && PENABLE && have) begin
            chk("access_pwrite", PWRITE, cur.cmd.write);
            chk("access_paddr",  PADDR,  cur.cmd.addr);
            chk("access_pwdata", PWDATA, cur.cmd.wdata);
            if (cnt > 0) begin
               cnt--;
               PREADY  = 1'b0;
               PSLVERR = 1'($urandom);
               PRDATA  = $urandom;
            end else begin
               PREADY  = 1'b1;
               PSLVERR = cur.err;
               PRDATA  = cur.cmd.write ? $urandom : cur.rdata;
            end
         end else begin
            if (PENABLE) chk("penable_without_psel_or_setup", PENABLE, 0);
            if (have) begin
               chk("hold_paddr",  PADDR,  cur.cmd.addr);
               chk("hold_pwdata", PWDATA, cur.cmd.wdata);
            end
            PREADY  = 1'($urandom);
            PSLVERR = 1'($urandom);
            PRDATA  = $urandom;
         end
      end
   end

   // ---------------- response monitor / scoreboard ----------------
   initial begin
      exp_t e;
      bit   holding;
      bit   busy;
      holding = 1'b0;
      busy    = 1'b0;
      forever begin
         @(negedge pclk);
         if (!rstn) begin
            holding = 1'b0;
            busy    = 1'b0;
         end else begin
            chk("cmd_ready", cmd_ready, !busy);
            if (rsp_valid && !holding) begin
               if (exp_q.size() == 0) begin
                  chk("rsp_unexpected", rsp_valid, 0);
               end else begin
                  e       = exp_q.pop_front();
                  holding = 1'b1;
                  chk("rsp_rdata",   rsp_rdata,   e.rdata);
                  chk("rsp_err",     rsp_err,     e.err);
                  chk("rsp_timeout", rsp_timeout, e.tmo);
                  chk("rsp_cycle",   64'(cyc),    64'(e.due));
               end
            end
            if (holding) begin
               if (!rsp_valid) begin
                  chk("rsp_dropped", rsp_valid, 1);
                  holding = 1'b0;
                  busy    = 1'b0;
               end else if (rsp_ready) begin
                  chk("rsp_rdata_stable",   rsp_rdata,   e.rdata);
                  chk("rsp_err_stable",     rsp_err,     e.err);
                  chk("rsp_timeout_stable", rsp_timeout, e.tmo);
                  holding = 1'b0;
                  busy    = 1'b0;
               end
            end
            if (cmd_valid && cmd_ready) busy = 1'b1;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
